// File: rtl/lsu_sq_pkg.sv
// Shared types and default sizes for the LSU store queue.
package lsu_sq_pkg;

    localparam int SQ_DATA_WIDTH = 32;
    localparam int SQ_ADDR_WIDTH = 32;
    localparam int SQ_TAG_WIDTH  = 6;
    localparam int SQ_DEPTH_DEF  = 4;

    typedef enum logic [1:0] {
        LSU_SB = 2'd0,
        LSU_SH = 2'd1,
        LSU_SW = 2'd2
    } lsu_func_t;

    typedef enum logic [1:0] {
        SQ_IDLE   = 2'd0,
        SQ_WRITE  = 2'd1,
        SQ_NOTIFY = 2'd2
    } sq_state_t;

endpackage

// File: rtl/lsu_sq_if.sv
// Store-queue bus bundle: allocation from LSU_ID, ROB retire, D$ write port and LQ notify.
interface lsu_sq_if import lsu_sq_pkg::*; #(
    parameter int DATA_WIDTH = SQ_DATA_WIDTH,
    parameter int ADDR_WIDTH = SQ_ADDR_WIDTH,
    parameter int TAG_WIDTH  = SQ_TAG_WIDTH
);
    // Handshakes: an allocation is taken only when i_alloc_en && !o_full in the same cycle;
    // o_dc_wr_en holds with stable addr/data/func until i_dc_wr_done is seen high at an edge;
    // o_lq_retire_en is a one-cycle pulse with no back-pressure. Data is zero when its enable is low.
    logic                  o_full;
    logic [TAG_WIDTH-1:0]  i_alloc_tag;
    logic [ADDR_WIDTH-1:0] i_alloc_addr;
    logic [DATA_WIDTH-1:0] i_alloc_data;
    lsu_func_t             i_alloc_lsu_func;
    logic                  i_alloc_en;
    logic [TAG_WIDTH-1:0]  i_rob_retire_tag;
    logic                  i_rob_retire_en;
    logic [ADDR_WIDTH-1:0] o_dc_wr_addr;
    logic [DATA_WIDTH-1:0] o_dc_wr_data;
    lsu_func_t             o_dc_wr_lsu_func;
    logic                  o_dc_wr_en;
    logic                  i_dc_wr_done;
    logic [ADDR_WIDTH-1:0] o_lq_retire_addr;
    lsu_func_t             o_lq_retire_lsu_func;
    logic                  o_lq_retire_en;

    modport slave (
        output o_full,
        input  i_alloc_tag, i_alloc_addr, i_alloc_data, i_alloc_lsu_func, i_alloc_en,
        input  i_rob_retire_tag, i_rob_retire_en,
        output o_dc_wr_addr, o_dc_wr_data, o_dc_wr_lsu_func, o_dc_wr_en,
        input  i_dc_wr_done,
        output o_lq_retire_addr, o_lq_retire_lsu_func, o_lq_retire_en
    );

    modport master (
        input  o_full,
        output i_alloc_tag, i_alloc_addr, i_alloc_data, i_alloc_lsu_func, i_alloc_en,
        output i_rob_retire_tag, i_rob_retire_en,
        input  o_dc_wr_addr, o_dc_wr_data, o_dc_wr_lsu_func, o_dc_wr_en,
        output i_dc_wr_done,
        input  o_lq_retire_addr, o_lq_retire_lsu_func, o_lq_retire_en
    );

endinterface

// File: rtl/lsu_sq_retire_fifo.sv
// Slot-index FIFO recording ROB retire order; never overflows since entries <= valid slots.
module lsu_sq_retire_fifo #(
    parameter int DEPTH = 4,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          i_push,
    input  logic [IW-1:0] i_push_idx,
    input  logic          i_pop,
    output logic [IW-1:0] o_head,
    output logic          o_empty
);

    logic [IW-1:0] r_mem [DEPTH];
    logic [IW-1:0] r_head;
    logic [IW-1:0] r_tail;
    logic [IW:0]   r_count;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_tail] <= i_push_idx;
                r_tail        <= r_tail + IW'(1);
            end
            if (i_pop) r_head <= r_head + IW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (IW+1)'(1);
                2'b01:   r_count <= r_count - (IW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/lsu_sq.sv
// LSU store queue: holds stores speculatively until ROB retire, then drains them to D$ in
// retire order and reports each completed write to the load queue.
module lsu_sq import lsu_sq_pkg::*; #(
    parameter int DATA_WIDTH = SQ_DATA_WIDTH,
    parameter int ADDR_WIDTH = SQ_ADDR_WIDTH,
    parameter int TAG_WIDTH  = SQ_TAG_WIDTH,
    parameter int SQ_DEPTH   = SQ_DEPTH_DEF
) (
    input  logic      clk,
    input  logic      n_rst,
    input  logic      i_flush,
    lsu_sq_if.slave   sq_if,
    output sq_state_t o_dbg_state
);

    localparam int IW = $clog2(SQ_DEPTH);

    logic [ADDR_WIDTH-1:0] r_addr [SQ_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [SQ_DEPTH];
    lsu_func_t             r_func [SQ_DEPTH];
    logic [TAG_WIDTH-1:0]  r_tag  [SQ_DEPTH];
    logic [SQ_DEPTH-1:0]   r_valid;
    logic [SQ_DEPTH-1:0]   r_retired;

    sq_state_t             r_state;
    logic [IW-1:0]         r_cur_idx;
    logic                  r_dc_wr_en;
    logic [ADDR_WIDTH-1:0] r_dc_wr_addr;
    logic [DATA_WIDTH-1:0] r_dc_wr_data;
    lsu_func_t             r_dc_wr_func;
    logic                  r_lq_en;
    logic [ADDR_WIDTH-1:0] r_lq_addr;
    lsu_func_t             r_lq_func;

    logic [IW-1:0] w_alloc_idx;
    logic [IW-1:0] w_ret_idx;
    logic          w_ret_match;
    logic          w_ret_push;
    logic          w_full;
    logic          w_alloc_do;
    logic          w_free;
    logic          w_pop;
    logic [IW-1:0] w_fifo_head;
    logic          w_fifo_empty;

    // Descending scans so the lowest matching index is the one left standing.
    always_comb begin
        w_alloc_idx = '0;
        w_ret_idx   = '0;
        w_ret_match = 1'b0;
        for (int i = SQ_DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) w_alloc_idx = IW'(i);
            if (r_valid[i] && !r_retired[i] && (r_tag[i] == sq_if.i_rob_retire_tag)) begin
                w_ret_idx   = IW'(i);
                w_ret_match = 1'b1;
            end
        end
    end

    assign w_full     = &r_valid;
    assign w_alloc_do = sq_if.i_alloc_en && !w_full && !i_flush;
    assign w_ret_push = sq_if.i_rob_retire_en && w_ret_match;
    assign w_free     = (r_state == SQ_NOTIFY);
    assign w_pop      = (r_state == SQ_WRITE) && sq_if.i_dc_wr_done;

    lsu_sq_retire_fifo #(.DEPTH(SQ_DEPTH), .IW(IW)) u_retire_fifo (
        .clk        (clk),
        .n_rst      (n_rst),
        .i_push     (w_ret_push),
        .i_push_idx (w_ret_idx),
        .i_pop      (w_pop),
        .o_head     (w_fifo_head),
        .o_empty    (w_fifo_empty)
    );

    // Free, alloc and retire always target distinct slots; a retire beats a same-cycle flush.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                r_addr[i] <= '0;
                r_data[i] <= '0;
                r_func[i] <= LSU_SB;
                r_tag[i]  <= '0;
            end
            r_valid   <= '0;
            r_retired <= '0;
        end else begin
            for (int i = 0; i < SQ_DEPTH; i++) begin
                if (w_free && (r_cur_idx == IW'(i))) begin
                    r_valid[i]   <= 1'b0;
                    r_retired[i] <= 1'b0;
                end else if (w_alloc_do && (w_alloc_idx == IW'(i))) begin
                    r_addr[i]    <= sq_if.i_alloc_addr;
                    r_data[i]    <= sq_if.i_alloc_data;
                    r_func[i]    <= sq_if.i_alloc_lsu_func;
                    r_tag[i]     <= sq_if.i_alloc_tag;
                    r_valid[i]   <= 1'b1;
                    r_retired[i] <= 1'b0;
                end else if (w_ret_push && (w_ret_idx == IW'(i))) begin
                    r_retired[i] <= 1'b1;
                end else if (i_flush && !r_retired[i]) begin
                    r_valid[i]   <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state      <= SQ_IDLE;
            r_cur_idx    <= '0;
            r_dc_wr_en   <= 1'b0;
            r_dc_wr_addr <= '0;
            r_dc_wr_data <= '0;
            r_dc_wr_func <= LSU_SB;
            r_lq_en      <= 1'b0;
            r_lq_addr    <= '0;
            r_lq_func    <= LSU_SB;
        end else begin
            case (r_state)
                SQ_IDLE: begin
                    if (!w_fifo_empty) begin
                        r_cur_idx    <= w_fifo_head;
                        r_dc_wr_en   <= 1'b1;
                        r_dc_wr_addr <= r_addr[w_fifo_head];
                        r_dc_wr_data <= r_data[w_fifo_head];
                        r_dc_wr_func <= r_func[w_fifo_head];
                        r_state      <= SQ_WRITE;
                    end
                end
                SQ_WRITE: begin
                    if (sq_if.i_dc_wr_done) begin
                        r_dc_wr_en   <= 1'b0;
                        r_dc_wr_addr <= '0;
                        r_dc_wr_data <= '0;
                        r_dc_wr_func <= LSU_SB;
                        r_lq_en      <= 1'b1;
                        r_lq_addr    <= r_addr[r_cur_idx];
                        r_lq_func    <= r_func[r_cur_idx];
                        r_state      <= SQ_NOTIFY;
                    end
                end
                SQ_NOTIFY: begin
                    r_lq_en   <= 1'b0;
                    r_lq_addr <= '0;
                    r_lq_func <= LSU_SB;
                    r_state   <= SQ_IDLE;
                end
                default: r_state <= SQ_IDLE;
            endcase
        end
    end

    assign sq_if.o_full               = w_full;
    assign sq_if.o_dc_wr_en           = r_dc_wr_en;
    assign sq_if.o_dc_wr_addr         = r_dc_wr_addr;
    assign sq_if.o_dc_wr_data         = r_dc_wr_data;
    assign sq_if.o_dc_wr_lsu_func     = r_dc_wr_func;
    assign sq_if.o_lq_retire_en       = r_lq_en;
    assign sq_if.o_lq_retire_addr     = r_lq_addr;
    assign sq_if.o_lq_retire_lsu_func = r_lq_func;
    assign o_dbg_state                = r_state;

endmodule

// File: tb/tb_lsu_sq.sv
// Store-queue bench: slot-array reference model feeds expected D$/LQ queues, a monitor checks them.
module tb_lsu_sq;
    import lsu_sq_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int TW    = 6;
    localparam int DEPTH = 4;

    typedef struct {
        bit            valid;
        bit            retired;
        logic [TW-1:0] tag;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        lsu_func_t     func;
    } slot_t;

    logic      clk = 1'b0;
    logic      n_rst = 1'b0;
    logic      i_flush = 1'b0;
    sq_state_t dbg_state;
    bit        dc_hold = 1'b0;

    lsu_sq_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) sq_if ();

    lsu_sq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW), .SQ_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .i_flush     (i_flush),
        .sq_if       (sq_if),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    slot_t               m_slot [DEPTH];
    int                  drain_q [$];
    logic [AW+DW+1:0]    exp_q [$];
    logic [AW+1:0]       exp_lq_q [$];
    int                  errors = 0;
    int                  checks = 0;
    logic [TW-1:0]       next_tag = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one call per cycle, describing what the coming clock edge does.
    task automatic model_step(input bit fl, input bit ae, input logic [TW-1:0] at,
                              input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                              input lsu_func_t af, input bit re, input logic [TW-1:0] rt);
        bit full = 1'b1;
        int aidx = -1;
        int ridx = -1;
        for (int i = 0; i < DEPTH; i++) begin
            if (!m_slot[i].valid) begin
                full = 1'b0;
                if (aidx < 0) aidx = i;
            end
            if (re && ridx < 0 && m_slot[i].valid && !m_slot[i].retired && m_slot[i].tag == rt)
                ridx = i;
        end
        check("o_full", 64'(sq_if.o_full), 64'(full));
        if (sq_if.o_lq_retire_en) begin
            if (drain_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL notify_without_retired_store: got lq_en 1 expected 0 at %0t", $time);
            end else begin
                int fidx = drain_q.pop_front();
                m_slot[fidx].valid   = 1'b0;
                m_slot[fidx].retired = 1'b0;
            end
        end
        if (ridx >= 0) begin
            m_slot[ridx].retired = 1'b1;
            drain_q.push_back(ridx);
            exp_q.push_back({m_slot[ridx].addr, m_slot[ridx].data, m_slot[ridx].func});
            exp_lq_q.push_back({m_slot[ridx].addr, m_slot[ridx].func});
        end
        if (ae && !full && !fl) begin
            m_slot[aidx].valid   = 1'b1;
            m_slot[aidx].retired = 1'b0;
            m_slot[aidx].tag     = at;
            m_slot[aidx].addr    = aa;
            m_slot[aidx].data    = ad;
            m_slot[aidx].func    = af;
        end
        if (fl) begin
            for (int i = 0; i < DEPTH; i++)
                if (m_slot[i].valid && !m_slot[i].retired) m_slot[i].valid = 1'b0;
        end
    endtask

    task automatic drive(input bit fl, input bit ae, input logic [TW-1:0] at,
                         input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                         input lsu_func_t af, input bit re, input logic [TW-1:0] rt);
        @(negedge clk);
        i_flush                = fl;
        sq_if.i_alloc_en       = ae;
        sq_if.i_alloc_tag      = at;
        sq_if.i_alloc_addr     = aa;
        sq_if.i_alloc_data     = ad;
        sq_if.i_alloc_lsu_func = af;
        sq_if.i_rob_retire_en  = re;
        sq_if.i_rob_retire_tag = rt;
        model_step(fl, ae, at, aa, ad, af, re, rt);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, '0, '0, '0, LSU_SB, 1'b0, '0);
    endtask

    task automatic do_alloc(input logic [TW-1:0] t, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input lsu_func_t f);
        drive(1'b0, 1'b1, t, a, d, f, 1'b0, '0);
    endtask

    task automatic do_retire(input logic [TW-1:0] t);
        drive(1'b0, 1'b0, '0, '0, '0, LSU_SB, 1'b1, t);
    endtask

    task automatic do_flush();
        drive(1'b1, 1'b0, '0, '0, '0, LSU_SB, 1'b0, '0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_lq_q.size() != 0 || drain_q.size() != 0 || dbg_state != SQ_IDLE) && n < 200) begin
            idle(1);
            n++;
        end
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_lq_q.size());
        end
    endtask

    task automatic retire_all();
        logic [TW-1:0] tags [$];
        for (int i = 0; i < DEPTH; i++)
            if (m_slot[i].valid && !m_slot[i].retired) tags.push_back(m_slot[i].tag);
        foreach (tags[k]) do_retire(tags[k]);
        wait_drain();
    endtask

    // D$ responder: completes each write after a few cycles unless held.
    initial begin
        int dly = 2;
        sq_if.i_dc_wr_done = 1'b0;
        forever begin
            @(negedge clk);
            sq_if.i_dc_wr_done = 1'b0;
            if (n_rst && !dc_hold && sq_if.o_dc_wr_en) begin
                if (dly == 0) begin
                    sq_if.i_dc_wr_done = 1'b1;
                    dly = $urandom_range(0, 3);
                end else begin
                    dly--;
                end
            end
        end
    end

    // Monitor: each new D$ write and each LQ notify pops and checks its expected entry.
    initial begin
        bit prev_wr = 1'b0;
        logic [AW+DW+1:0] e;
        logic [AW+1:0] l;
        forever begin
            @(negedge clk);
            if (n_rst) begin
                if (sq_if.o_dc_wr_en && !prev_wr) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL dc_wr_unexpected: got addr %0h expected no write", sq_if.o_dc_wr_addr);
                    end else begin
                        e = exp_q.pop_front();
                        check("dc_wr_addr", 64'(sq_if.o_dc_wr_addr), 64'(e[AW+DW+1:DW+2]));
                        check("dc_wr_data", 64'(sq_if.o_dc_wr_data), 64'(e[DW+1:2]));
                        check("dc_wr_func", 64'(sq_if.o_dc_wr_lsu_func), 64'(e[1:0]));
                    end
                end
                if (!sq_if.o_dc_wr_en) check("dc_wr_addr_idle_zero", 64'(sq_if.o_dc_wr_addr), 64'd0);
                if (sq_if.o_lq_retire_en) begin
                    if (exp_lq_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL lq_retire_unexpected: got addr %0h expected no notify", sq_if.o_lq_retire_addr);
                    end else begin
                        l = exp_lq_q.pop_front();
                        check("lq_retire_addr", 64'(sq_if.o_lq_retire_addr), 64'(l[AW+1:2]));
                        check("lq_retire_func", 64'(sq_if.o_lq_retire_lsu_func), 64'(l[1:0]));
                    end
                end
            end
            prev_wr = sq_if.o_dc_wr_en;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [TW-1:0] cand [$];
        logic [TW-1:0] ta, tb;
        bit ae, fl, re;
        logic [TW-1:0] rt;
        int r, n;

        sq_if.i_alloc_en       = 1'b0;
        sq_if.i_alloc_tag      = '0;
        sq_if.i_alloc_addr     = '0;
        sq_if.i_alloc_data     = '0;
        sq_if.i_alloc_lsu_func = LSU_SB;
        sq_if.i_rob_retire_en  = 1'b0;
        sq_if.i_rob_retire_tag = '0;
        for (int i = 0; i < DEPTH; i++) m_slot[i] = '{1'b0, 1'b0, '0, '0, '0, LSU_SB};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_full", 64'(sq_if.o_full), 64'd0);
        check("rst_dc_wr_en", 64'(sq_if.o_dc_wr_en), 64'd0);
        check("rst_lq_en", 64'(sq_if.o_lq_retire_en), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(SQ_IDLE));
        n_rst = 1'b1;

        // Single store, no retire: no D$ activity; then retire and drain
        do_alloc(6'd3, 32'h100, 32'hDEADBEEF, LSU_SW);
        idle(5);
        check("no_write_before_retire", 64'(sq_if.o_dc_wr_en), 64'd0);
        do_retire(6'd3);
        wait_drain();

        // Out-of-order retire: tag 7 writes before tag 5, tag 6 stays
        do_alloc(6'd5, 32'h200, 32'h55, LSU_SB);
        do_alloc(6'd6, 32'h300, 32'h66, LSU_SH);
        do_alloc(6'd7, 32'h400, 32'h77, LSU_SW);
        do_retire(6'd7);
        do_retire(6'd5);
        wait_drain();
        idle(3);
        do_retire(6'd6);
        wait_drain();

        // Fill to full, one extra alloc dropped, drain one, refill the freed slot
        for (int i = 0; i <= DEPTH; i++)
            do_alloc(6'(10 + i), 32'h1000 + 32'(i * 4), 32'hA000 + 32'(i), LSU_SW);
        idle(1);
        check("full_after_fill", 64'(sq_if.o_full), 64'd1);
        do_retire(6'd11);
        wait_drain();
        do_alloc(6'd20, 32'h2000, 32'hBEEF, LSU_SH);
        idle(1);
        retire_all();

        // Flush: unretired store dropped, retired store still drains
        do_alloc(6'd30, 32'h3000, 32'h3030, LSU_SW);
        do_alloc(6'd31, 32'h3100, 32'h3131, LSU_SB);
        do_retire(6'd30);
        do_flush();
        wait_drain();
        do_retire(6'd31);
        idle(8);

        // Flush together with alloc and a same-tag retire
        do_alloc(6'd32, 32'h3200, 32'h3232, LSU_SH);
        drive(1'b1, 1'b1, 6'd33, 32'h3300, 32'h3333, LSU_SW, 1'b1, 6'd32);
        wait_drain();
        do_retire(6'd33);
        idle(8);

        // Async reset in the middle of a D$ write
        dc_hold = 1'b1;
        do_alloc(6'd40, 32'h4000, 32'h4040, LSU_SW);
        do_alloc(6'd41, 32'h4100, 32'h4141, LSU_SB);
        do_retire(6'd40);
        n = 0;
        while (!sq_if.o_dc_wr_en && n < 20) begin
            idle(1);
            n++;
        end
        check("wr_en_before_reset", 64'(sq_if.o_dc_wr_en), 64'd1);
        #2 n_rst = 1'b0;
        #1;
        check("reset_drops_wr_en", 64'(sq_if.o_dc_wr_en), 64'd0);
        check("reset_full", 64'(sq_if.o_full), 64'd0);
        check("reset_state", 64'(dbg_state), 64'(SQ_IDLE));
        for (int i = 0; i < DEPTH; i++) m_slot[i] = '{1'b0, 1'b0, '0, '0, '0, LSU_SB};
        drain_q.delete();
        exp_q.delete();
        exp_lq_q.delete();
        @(negedge clk);
        n_rst = 1'b1;
        dc_hold = 1'b0;
        idle(6);
        do_retire(6'd41);
        idle(6);

        // Randomized traffic
        next_tag = 6'd50;
        for (int c = 0; c < 1500; c++) begin
            ae = ($urandom_range(0, 99) < 45);
            fl = ($urandom_range(0, 99) < 3);
            r  = $urandom_range(0, 99);
            re = 1'b0;
            rt = '0;
            cand.delete();
            for (int i = 0; i < DEPTH; i++)
                if (m_slot[i].valid && !m_slot[i].retired) cand.push_back(m_slot[i].tag);
            if (r < 35 && cand.size() > 0) begin
                re = 1'b1;
                rt = cand[$urandom_range(0, cand.size() - 1)];
            end else if (r >= 95) begin
                re = 1'b1;
                rt = TW'($urandom_range(0, 63));
            end
            drive(fl, ae, next_tag, $urandom, $urandom, lsu_func_t'($urandom_range(0, 2)), re, rt);
            if (ae) next_tag = next_tag + 6'd1;
        end
        retire_all();
        idle(4);
        check("exp_q_empty_at_end", 64'(exp_q.size()), 64'd0);
        check("exp_lq_q_empty_at_end", 64'(exp_lq_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
